// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Feature macro: KEYPAD_AUTOREPEAT_EN (auto-repeat while a key is held).
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    RELEASE
  } state_e;

  localparam logic [3:0] ROWS_IDLE = 4'hF;
  localparam logic [3:0] COL_RESET = 4'b1110;

  // Lowest pulled-down row wins when several rows are low.
  function automatic logic [1:0] row_to_index(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    priority case (1'b1)
      !rows[0]: idx = 2'd0;
      !rows[1]: idx = 2'd1;
      !rows[2]: idx = 2'd2;
      !rows[3]: idx = 2'd3;
      default:  idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins and entry-register bundle.
// Feature macro: KEYPAD_AUTOREPEAT_EN (no effect on this bundle).
interface keypad_scanner_if;
  logic [3:0] KEY_R;
  logic       key_clr;
  logic [3:0] KEY_C;
  logic [7:0] out;
  logic [3:0] key_code;
  logic       key_valid;

  modport master (
    output KEY_R, key_clr,
    input  KEY_C, out, key_code, key_valid
  );

  modport slave (
    input  KEY_R, key_clr,
    output KEY_C, out, key_code, key_valid
  );
endinterface

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchronizer for the asynchronous keypad rows.
// Feature macro: KEYPAD_AUTOREPEAT_EN (no effect here).
module key_sync
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] s1_q;
  logic [3:0] s2_q;

  // Rows idle high out of reset so nothing looks pressed.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1_q <= ROWS_IDLE;
      s2_q <= ROWS_IDLE;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, debounce, hex entry register.
// Feature macro: KEYPAD_AUTOREPEAT_EN (repeat strobes on held key).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000,
  parameter int REPEAT_CNT   = 500000
) (
  input  logic            clk,
  input  logic            clr,
  keypad_scanner_if.slave kp
);

  localparam int CMAX =
    (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DWELL_END = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_END    = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0] REL_END   = CW'(DEBOUNCE_CNT - 1);

  if (SCAN_DIV < 4) begin : g_bad_div
    $error("SCAN_DIV must be >= 4");
  end
  if (DEBOUNCE_CNT < 2) begin : g_bad_db
    $error("DEBOUNCE_CNT must be >= 2");
  end
  if (REPEAT_CNT < 1) begin : g_bad_rep
    $error("REPEAT_CNT must be >= 1");
  end

  state_e        state_q, state_d;
  logic [1:0]    c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    pat_q, pat_d;
  logic [3:0]    val_q, val_d;
  logic [3:0]    col_q;
  logic [7:0]    out_q, out_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          emit;
  logic [3:0]    rows;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CNT + 1);
  localparam logic [RW-1:0] REP_END = RW'(REPEAT_CNT - 1);
  logic [RW-1:0] rep_q, rep_d;
`endif

  key_sync u_sync (
    .clk (clk),
    .clr (clr),
    .d_i (kp.KEY_R),
    .q_o (rows)
  );

  // Next-state: scan dwell, press debounce, release wait, entry shift.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    val_d   = val_q;
    out_d   = out_q;
    code_d  = code_q;
    valid_d = 1'b0;
    emit    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d   = '0;
`endif
    unique case (state_q)
      SCAN: begin
        if (cnt_q == DWELL_END) begin
          cnt_d = '0;
          if (rows != ROWS_IDLE) begin
            pat_d   = rows;
            val_d   = {row_to_index(rows), c_q};
            state_d = DEBOUNCE;
          end else begin
            c_d = c_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (cnt_q == DB_END) begin
          emit    = 1'b1;
          cnt_d   = '0;
          state_d = RELEASE;
        end else if (rows != pat_q) begin
          cnt_d   = '0;
          c_d     = c_q + 2'd1;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (rows != ROWS_IDLE) begin
          cnt_d = '0;
        end else if (cnt_q == REL_END) begin
          cnt_d   = '0;
          c_d     = c_q + 2'd1;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        if (rows == pat_q) begin
          if (rep_q == REP_END) begin
            emit = 1'b1;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end
`endif
      end
      default: state_d = SCAN;
    endcase
    if (emit) begin
      valid_d = 1'b1;
      code_d  = val_q;
      out_d   = {out_q[3:0], val_q};
    end
    if (kp.key_clr) begin
      out_d = 8'h00;
    end
  end

  // State and output registers; column drive follows next column.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= SCAN;
      c_q     <= 2'd0;
      cnt_q   <= '0;
      pat_q   <= ROWS_IDLE;
      val_q   <= 4'h0;
      col_q   <= COL_RESET;
      out_q   <= 8'h00;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      val_q   <= val_d;
      col_q   <= ~(4'b0001 << c_d);
      out_q   <= out_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  // Hold timer between repeat strobes.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  assign kp.KEY_C     = col_q;
  assign kp.out       = out_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;

endmodule
